// File: rtl/game_pkg.sv
// Shared encodings and helpers for the escape-game sequencer and the UI renderer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8
    } state_t;

    // FIND_LIGHT is kept so the renderer's encoding table stays complete.
    typedef enum logic [1:0] {
        TODO_NONE       = 2'd0,
        TODO_FIND_KEY   = 2'd1,
        TODO_FIND_LIGHT = 2'd2,
        TODO_FIND_DOOR  = 2'd3
    } todo_t;

    localparam logic [1:0] HEART_MAX = 2'd3;
    localparam logic [1:0] KEY_MAX   = 2'd3;

    // Menu item counts per screen.
    localparam logic [1:0] ITEMS_TITLE    = 2'd3;
    localparam logic [1:0] ITEMS_SUCCESS  = 2'd2;
    localparam logic [1:0] ITEMS_FAIL     = 2'd2;
    localparam logic [1:0] ITEMS_SUCCESS3 = 2'd1;
    localparam logic [1:0] ITEMS_STAFF    = 2'd1;

    // Stage 1 is always playable; bit 0 has no stage behind it.
    localparam logic [3:0] PLAY_VALID_RST = 4'b0010;

    function automatic logic [1:0] menu_items(input state_t s);
        case (s)
            ST_TITLE:    return ITEMS_TITLE;
            ST_SUCCESS1: return ITEMS_SUCCESS;
            ST_SUCCESS2: return ITEMS_SUCCESS;
            ST_FAIL:     return ITEMS_FAIL;
            ST_SUCCESS3: return ITEMS_SUCCESS3;
            ST_STAFF:    return ITEMS_STAFF;
            default:     return 2'd1;
        endcase
    endfunction

    function automatic logic is_stage(input state_t s);
        return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
    endfunction

    // Stage number 1..3 for a stage screen, 0 otherwise.
    function automatic logic [1:0] stage_index(input state_t s);
        case (s)
            ST_STAGE1: return 2'd1;
            ST_STAGE2: return 2'd2;
            ST_STAGE3: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    function automatic state_t stage_state(input logic [1:0] k);
        case (k)
            2'd2:    return ST_STAGE2;
            2'd3:    return ST_STAGE3;
            default: return ST_STAGE1;
        endcase
    endfunction

    function automatic state_t success_state(input logic [1:0] k);
        case (k)
            2'd2:    return ST_SUCCESS2;
            2'd3:    return ST_SUCCESS3;
            default: return ST_SUCCESS1;
        endcase
    endfunction

    // Wrapping cursor move; up and down together cancel out.
    function automatic logic [1:0] cursor_step(input logic [1:0] cur, input logic [1:0] items,
                                               input logic up, input logic down);
        if (up && !down)
            return (cur == 2'd0) ? items - 2'd1 : cur - 2'd1;
        if (down && !up)
            return (cur == items - 2'd1) ? 2'd0 : cur + 2'd1;
        return cur;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundles the button/gameplay pulses and the game-state outputs of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are one-cycle strobes, outputs are level state.
interface game_flow_ctrl_if;
    import game_pkg::*;

    logic       btn_up;
    logic       btn_down;
    logic       btn_enter;
    logic       key_got;
    logic       door_reached;
    logic       hit;

    state_t     state;
    logic [1:0] key_find;
    logic [1:0] heart;
    todo_t      todo;
    logic [3:0] play_valid;
    logic [1:0] cursor;
    logic       invuln;

    // Producer of pulses / consumer of game state (input conditioning + renderer side).
    modport master (
        output btn_up, btn_down, btn_enter, key_got, door_reached, hit,
        input  state, key_find, heart, todo, play_valid, cursor, invuln
    );

    // The sequencer itself.
    modport slave (
        input  btn_up, btn_down, btn_enter, key_got, door_reached, hit,
        output state, key_find, heart, todo, play_valid, cursor, invuln
    );
endinterface

// File: rtl/game_flow_ctrl_hit_guard.sv
// Invulnerability window after a damaging hit: down-counter plus active flag.
// Latency: active rises the cycle after start and stays high exactly INVULN_CYCLES cycles.
// Backpressure: none; clear wins over start in the same cycle.
module hit_guard #(
    parameter int INVULN_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic active
);
    localparam int             CW   = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam logic [CW-1:0]  LOAD = CW'(INVULN_CYCLES - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] count_q;
    logic          active_q;

    // Load on an accepted hit, count down to zero, then drop the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else if (clear) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            count_q  <= LOAD;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (count_q == '0)
                active_q <= 1'b0;
            else
                count_q <= count_q - ONE;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game screen sequencer: menus, stage progress, lives, keys and stage unlocks.
// Latency: every output is registered and reflects an input pulse on the next edge.
// Backpressure: none; pulses are always consumed (or deliberately ignored) the cycle they arrive.
import game_pkg::*;

module game_flow_ctrl #(
    parameter int INVULN_CYCLES = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    game_flow_ctrl_if.slave  bus
);
    state_t     state_q;
    logic [1:0] key_find_q;
    logic [1:0] heart_q;
    todo_t      todo_q;
    logic [3:0] play_valid_q;
    logic [1:0] cursor_q;
    logic [1:0] last_stage_q;
    logic       guard_active;

    logic       in_stage;
    logic [1:0] k_cur;
    logic       hit_ok;
    logic       fatal;
    logic       key_inc;
    logic       key_done;
    logic       door_ok;
    logic       leave_stage;
    state_t     menu_ns;
    logic [1:0] enter_k;
    logic       enter_stage;

    // Event decode shared by the FSM and the hit guard control.
    always_comb begin
        in_stage = is_stage(state_q);
        k_cur    = stage_index(state_q);
        hit_ok   = in_stage && bus.hit && !guard_active;
        fatal    = hit_ok && (heart_q == 2'd1);
        key_inc  = in_stage && bus.key_got && (key_find_q != KEY_MAX);
        key_done = key_inc && (key_find_q == KEY_MAX - 2'd1);
        // The door only counts once the registered task says so, and loses to death
        // and to the key that would have unlocked it this same cycle.
        door_ok  = in_stage && bus.door_reached && (todo_q == TODO_FIND_DOOR)
                   && !fatal && !key_done;
        leave_stage = fatal || door_ok;

        menu_ns = state_q;
        enter_k = last_stage_q;
        if (!in_stage && bus.btn_enter) begin
            case (state_q)
                ST_TITLE: begin
                    if (play_valid_q[cursor_q + 2'd1]) begin
                        menu_ns = stage_state(cursor_q + 2'd1);
                        enter_k = cursor_q + 2'd1;
                    end
                end
                ST_SUCCESS1: begin
                    menu_ns = (cursor_q == 2'd0) ? ST_STAGE2 : ST_TITLE;
                    enter_k = 2'd2;
                end
                ST_SUCCESS2: begin
                    menu_ns = (cursor_q == 2'd0) ? ST_STAGE3 : ST_TITLE;
                    enter_k = 2'd3;
                end
                ST_SUCCESS3: menu_ns = ST_STAFF;
                ST_STAFF:    menu_ns = ST_TITLE;
                ST_FAIL: begin
                    menu_ns = (cursor_q == 2'd0) ? stage_state(last_stage_q) : ST_TITLE;
                    enter_k = last_stage_q;
                end
                default: menu_ns = state_q;
            endcase
        end
        enter_stage = !in_stage && is_stage(menu_ns);
    end

    hit_guard #(
        .INVULN_CYCLES (INVULN_CYCLES)
    ) u_hit_guard (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (hit_ok),
        .clear  (enter_stage || leave_stage),
        .active (guard_active)
    );

    // Screen FSM with its progress registers (keys, lives, task, unlocks, cursor).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_TITLE;
            key_find_q   <= 2'd0;
            heart_q      <= HEART_MAX;
            todo_q       <= TODO_NONE;
            play_valid_q <= PLAY_VALID_RST;
            cursor_q     <= 2'd0;
            last_stage_q <= 2'd1;
        end else if (in_stage) begin
            cursor_q <= 2'd0;
            if (fatal) begin
                state_q <= ST_FAIL;
                heart_q <= 2'd0;
                todo_q  <= TODO_NONE;
            end else begin
                if (hit_ok)
                    heart_q <= heart_q - 2'd1;
                if (key_inc)
                    key_find_q <= key_find_q + 2'd1;
                if (key_done)
                    todo_q <= TODO_FIND_DOOR;
                if (door_ok) begin
                    state_q <= success_state(k_cur);
                    todo_q  <= TODO_NONE;
                    if (k_cur != 2'd3)
                        play_valid_q[k_cur + 2'd1] <= 1'b1;
                end
            end
        end else if (menu_ns != state_q) begin
            state_q  <= menu_ns;
            cursor_q <= 2'd0;
            if (enter_stage) begin
                key_find_q   <= 2'd0;
                heart_q      <= HEART_MAX;
                todo_q       <= TODO_FIND_KEY;
                last_stage_q <= enter_k;
            end
        end else if (!bus.btn_enter) begin
            // An enter press (even an ignored one) swallows any simultaneous move.
            cursor_q <= cursor_step(cursor_q, menu_items(state_q), bus.btn_up, bus.btn_down);
        end
    end

    assign bus.state      = state_q;
    assign bus.key_find   = key_find_q;
    assign bus.heart      = heart_q;
    assign bus.todo       = todo_q;
    assign bus.play_valid = play_valid_q;
    assign bus.cursor     = cursor_q;
    assign bus.invuln     = guard_active;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scoreboard bench for game_flow_ctrl with a short invulnerability window.
// Latency: expected snapshot is compared #1 after the edge that consumes each stimulus cycle.
// Backpressure: none; one expectation is queued per driven cycle.
module tb_game_flow_ctrl;

    typedef struct packed {
        logic [3:0] state;
        logic [1:0] key_find;
        logic [1:0] heart;
        logic [1:0] todo;
        logic [3:0] play_valid;
        logic [1:0] cursor;
        logic       invuln;
    } snap_t;

    // Pulse vector bits: up, down, enter, key, door, hit.
    localparam logic [5:0] P_NONE = 6'd0;
    localparam logic [5:0] P_UP   = 6'd1;
    localparam logic [5:0] P_DN   = 6'd2;
    localparam logic [5:0] P_EN   = 6'd4;
    localparam logic [5:0] P_KEY  = 6'd8;
    localparam logic [5:0] P_DOOR = 6'd16;
    localparam logic [5:0] P_HIT  = 6'd32;

    localparam snap_t RST_SNAP = '{state: 4'd0, key_find: 2'd0, heart: 2'd3, todo: 2'd0,
                                   play_valid: 4'b0010, cursor: 2'd0, invuln: 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .INVULN_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    snap_t exp_q[$];
    string name_q[$];
    snap_t e;
    int    checks = 0;
    int    errors = 0;

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic drive(input logic rst, input logic [5:0] p, input string nm);
        @(negedge clk);
        rst_n            = rst;
        bus.btn_up       = p[0];
        bus.btn_down     = p[1];
        bus.btn_enter    = p[2];
        bus.key_got      = p[3];
        bus.door_reached = p[4];
        bus.hit          = p[5];
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    // Monitor: pops one expectation per edge and compares it with the live outputs.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            snap_t want;
            snap_t got;
            string nm;
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {bus.state, bus.key_find, bus.heart, bus.todo, bus.play_valid,
                    bus.cursor, bus.invuln};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got st=%0d kf=%0d hp=%0d todo=%0d pv=%b cur=%0d inv=%0d, want st=%0d kf=%0d hp=%0d todo=%0d pv=%b cur=%0d inv=%0d",
                         nm, got.state, got.key_find, got.heart, got.todo, got.play_valid,
                         got.cursor, got.invuln, want.state, want.key_find, want.heart,
                         want.todo, want.play_valid, want.cursor, want.invuln);
            end
        end
    end

    // Hard stop if the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_enter = 1'b0;
        bus.key_got = 1'b0; bus.door_reached = 1'b0; bus.hit = 1'b0;

        // Reset, including pulses that must be swallowed by reset.
        e = RST_SNAP;
        drive(1'b0, P_NONE, "reset");
        drive(1'b0, P_HIT | P_KEY, "reset_hold");

        // Title menu: stage 3 locked, wrap, up+down cancel, enter on pre-move cursor.
        e.cursor = 2'd1; drive(1'b1, P_DN, "title_down1");
        e.cursor = 2'd2; drive(1'b1, P_DN, "title_down2");
        drive(1'b1, P_EN, "title_stage3_locked");
        drive(1'b1, P_UP | P_DN, "title_up_down_cancel");
        e.cursor = 2'd1; drive(1'b1, P_UP, "title_up1");
        e.cursor = 2'd0; drive(1'b1, P_UP, "title_up2");
        e.cursor = 2'd2; drive(1'b1, P_UP, "title_wrap_up");
        e.cursor = 2'd0; drive(1'b1, P_DN, "title_wrap_down");
        e.state = 4'd2; e.todo = 2'd1;
        drive(1'b1, P_EN | P_DN, "enter_stage1");

        // Stage 1: buttons ignored, door needs keys, key count saturates, door clears.
        drive(1'b1, P_DN, "stage_button_ignored");
        drive(1'b1, P_DOOR, "door_before_keys");
        e.key_find = 2'd1; drive(1'b1, P_KEY, "key1");
        e.key_find = 2'd2; drive(1'b1, P_KEY, "key2");
        e.key_find = 2'd3; e.todo = 2'd3; drive(1'b1, P_KEY, "key3_todo_door");
        drive(1'b1, P_KEY, "key_saturate");
        e.state = 4'd3; e.play_valid = 4'b0110; e.todo = 2'd0;
        drive(1'b1, P_DOOR, "door_success1");

        // SUCCESS1 item 1 back to title, then re-enter stage 1.
        e.cursor = 2'd1; drive(1'b1, P_DN, "success1_down");
        e.state = 4'd0; e.cursor = 2'd0; drive(1'b1, P_EN, "success1_to_title");
        e.state = 4'd2; e.key_find = 2'd0; e.todo = 2'd1;
        drive(1'b1, P_EN, "reenter_stage1");

        // Hits on six consecutive cycles with a 4-cycle window.
        e.heart = 2'd2; e.invuln = 1'b1; drive(1'b1, P_HIT, "hit_first");
        for (int i = 0; i < 3; i++) drive(1'b1, P_HIT, "hit_in_window");
        e.invuln = 1'b0; drive(1'b1, P_HIT, "hit_window_last");
        e.heart = 2'd1; e.invuln = 1'b1; drive(1'b1, P_HIT, "hit_after_window");
        for (int i = 0; i < 3; i++) drive(1'b1, P_NONE, "window_hold");
        e.invuln = 1'b0; drive(1'b1, P_NONE, "window_end");

        // Fatal hit beats a valid door.
        e.key_find = 2'd1; drive(1'b1, P_KEY, "fk1");
        e.key_find = 2'd2; drive(1'b1, P_KEY, "fk2");
        e.key_find = 2'd3; e.todo = 2'd3; drive(1'b1, P_KEY, "fk3");
        e.state = 4'd8; e.heart = 2'd0; e.todo = 2'd0;
        drive(1'b1, P_HIT | P_DOOR, "fatal_beats_door");
        drive(1'b1, P_KEY, "fail_ignores_key");
        e.cursor = 2'd1; drive(1'b1, P_DN, "fail_down");
        e.cursor = 2'd0; drive(1'b1, P_DN, "fail_wrap");
        e.state = 4'd2; e.heart = 2'd3; e.key_find = 2'd0; e.todo = 2'd1;
        drive(1'b1, P_EN, "fail_retry");

        // Non-fatal hit together with a valid door: both apply.
        e.key_find = 2'd1; drive(1'b1, P_KEY, "hk1");
        e.key_find = 2'd2; drive(1'b1, P_KEY, "hk2");
        e.key_find = 2'd3; e.todo = 2'd3; drive(1'b1, P_KEY, "hk3");
        e.state = 4'd3; e.heart = 2'd2; e.todo = 2'd0;
        drive(1'b1, P_HIT | P_DOOR, "hit_and_door");

        // Stage 2: third key with door in the same cycle ignores the door.
        e.state = 4'd4; e.heart = 2'd3; e.key_find = 2'd0; e.todo = 2'd1;
        drive(1'b1, P_EN, "success1_to_stage2");
        e.key_find = 2'd1; drive(1'b1, P_KEY, "s2k1");
        e.key_find = 2'd2; drive(1'b1, P_KEY, "s2k2");
        e.key_find = 2'd3; e.todo = 2'd3; drive(1'b1, P_KEY | P_DOOR, "key3_beats_door");
        e.state = 4'd5; e.play_valid = 4'b1110; e.todo = 2'd0;
        drive(1'b1, P_DOOR, "door_success2");

        // Stage 3 through credits back to title.
        e.state = 4'd6; e.key_find = 2'd0; e.todo = 2'd1;
        drive(1'b1, P_EN, "success2_to_stage3");
        e.key_find = 2'd1; drive(1'b1, P_KEY, "s3k1");
        e.key_find = 2'd2; drive(1'b1, P_KEY, "s3k2");
        e.key_find = 2'd3; e.todo = 2'd3; drive(1'b1, P_KEY, "s3k3");
        e.state = 4'd7; e.todo = 2'd0; drive(1'b1, P_DOOR, "door_success3");
        drive(1'b1, P_DN, "success3_single_item");
        e.state = 4'd1; drive(1'b1, P_EN, "success3_to_staff");
        e.state = 4'd0; drive(1'b1, P_EN, "staff_to_title");

        // Title now reaches stage 2; reset mid-stage inside the guard window.
        e.cursor = 2'd1; drive(1'b1, P_DN, "title_pick_stage2");
        e.state = 4'd4; e.cursor = 2'd0; e.key_find = 2'd0; e.heart = 2'd3; e.todo = 2'd1;
        drive(1'b1, P_EN, "title_to_stage2");
        e.key_find = 2'd1; drive(1'b1, P_KEY, "rk1");
        e.key_find = 2'd2; drive(1'b1, P_KEY, "rk2");
        e.heart = 2'd2; e.invuln = 1'b1; drive(1'b1, P_HIT, "rhit");
        e = RST_SNAP;
        drive(1'b0, P_HIT | P_KEY | P_DOOR, "reset_mid_stage");
        e.cursor = 2'd1; drive(1'b1, P_DN, "post_reset_down");
        drive(1'b1, P_EN, "post_reset_stage2_locked");

        // Let the monitor drain, then confirm nothing was left unchecked.
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
